telem_rx_deframer: RTL and testbench
====================================

// Module: telem_rx_deframer
// PURPOSE
// - Receive-side stage directly after the GT byte output in alchitry_top; consumes the decoded 8b/10b byte stream produced by the serial telemetry link.
// - Finds start-of-frame, gathers PKT_BYTES payload bytes, checks CRC-8, and emits one 88-bit telemetry packet per good frame.
// - Output format matches the transmit-side packet/packet_valid interface, so packets round-trip bit-exact.
// PARAMETERS
// - PKT_BYTES  11     payload bytes per frame; packet width = 8*PKT_BYTES
// - SOF_CHAR   8'hFB  K27.7 start-of-frame control character (rx_isk=1)
// - IDLE_CHAR  8'hBC  K28.5 idle/comma control character (rx_isk=1)
// - CRC_POLY   8'h07  CRC-8 polynomial; init 8'h00, MSB-first, no reflection, no final XOR
// - CNT_W      16     width of statistics counters
// PORTS
// - clk          in   1            recovered GT user clock; all logic on rising edge
// - rst_n        in   1            asynchronous, active-low reset
// - rx_data      in   8            decoded byte from GT
// - rx_isk       in   1            1 = rx_data is a K character
// - rx_valid     in   1            byte strobe; no byte is consumed when low
// - rx_aligned   in   1            GT byte alignment/lock indication
// - packet       out  8*PKT_BYTES  last good packet; first received byte lands in [MSB:MSB-7]
// - packet_valid out  1            one-cycle pulse per good packet
// - crc_err      out  1            one-cycle pulse: CRC mismatch, frame dropped
// - frame_err    out  1            one-cycle pulse: unexpected K char or non-K byte in IDLE
// - pkt_count    out  CNT_W        good packets, saturating
// - err_count    out  CNT_W        crc_err+frame_err events, saturating
// BEHAVIOUR
// - Reset: state=HUNT; packet=0; packet_valid, crc_err, frame_err, pkt_count, err_count all 0.
// - Only cycles with rx_valid=1 advance the FSM; rx_valid=0 holds all state, and the outputs pulse low.
// - FSM states:
//   - HUNT: wait for SOF_CHAR with rx_isk=1, then clear byte index and CRC and go to PAYLOAD. Other K chars are ignored. A data byte in HUNT raises frame_err, but only if a frame has ended since the last SOF; otherwise it is silent.
//   - PAYLOAD: data bytes shift into the assembly register and update the CRC. After byte PKT_BYTES-1, go to CHECK.
//   - CHECK: the next data byte is the received CRC. Match: packet <= assembly register, packet_valid=1 on the next cycle, pkt_count++. Mismatch: crc_err=1, err_count++, packet unchanged. Either way, return to HUNT.
// - K char in PAYLOAD or CHECK: frame_err=1, err_count++, frame discarded. If the K char is SOF_CHAR, restart in PAYLOAD with index 0; otherwise go to HUNT.
// - Latency: packet_valid rises exactly 1 clk after the CRC byte is sampled with rx_valid=1.
// - rx_aligned=0: forced to HUNT in the same cycle, partial frame discarded silently (no error pulse). packet and counters are kept.
// - Simultaneous crc_err and frame_err is impossible; err_count increments by at most 1 per cycle.
// - Counters saturate at all-ones and never wrap.
// - Byte index width is $clog2(PKT_BYTES); the comparison is against PKT_BYTES-1 with no wrap.
// - Back-to-back frames (SOF directly after the CRC byte, no idle) are accepted.
// - packet_valid pulses never exceed 1 per PKT_BYTES+2 byte strobes.
// STRUCTURE
// - Package telem_link_pkg holds:
//   - K_SOF / K_IDLE constants
//   - PKT_BYTES_DEFAULT
//   - typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} deframer_state_t
//   - function crc8_update(crc, byte); the transmit-side framer uses the same function
// - One sub-module, telem_crc8: registered CRC-8 accumulator with clear/enable/byte inputs and crc output. It is reused by the TX framer.
// - Statistics counters are inline; no separate module.
// TESTING
// 1. Idle stream of 0xBC K chars, then SOF + bytes 01..0B + correct CRC -> exactly one packet_valid, 1 clk after the CRC byte; packet=88'h0102030405060708090A0B; pkt_count=1.
// 2. Same frame with the CRC byte XOR 8'h01 -> crc_err pulse, no packet_valid, packet unchanged; err_count=1.
// 3. SOF, 5 data bytes, SOF, 11 data bytes, good CRC -> frame_err at the second SOF, then one packet_valid with the second frame's payload.
// 4. rx_aligned dropped for 1 clk mid-payload, then the rest of the frame -> no pulses, no packet_valid; the next complete frame is accepted normally.
// 5. rx_valid toggled 1/0 pseudo-randomly during a good frame -> same packet as test 1, with packet_valid 1 clk after the last strobed byte.
// 6. 1000 back-to-back good frames from the telemetry test counter through the serializer loopback model -> pkt_count=1000, err_count=0, all packets match the source in order. Preload counters near 16'hFFFF -> counters saturate at 16'hFFFF.

Source files
------------

// File: rtl/telem_link_pkg.sv
// Shared definitions for the serial telemetry link: control characters,
// frame geometry, deframer states and the CRC-8 byte update used on both ends.
package telem_link_pkg;

  localparam logic [7:0] K_SOF             = 8'hFB;  // K27.7
  localparam logic [7:0] K_IDLE            = 8'hBC;  // K28.5
  localparam int         PKT_BYTES_DEFAULT = 11;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } deframer_state_t;

  // MSB-first, non-reflected CRC-8 over one byte; init and final XOR are the caller's job.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly = CRC8_POLY);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/telem_crc8.sv
// Registered CRC-8 accumulator; clear wins over enable so a new frame can
// start on the same byte strobe that would otherwise update the running value.
module telem_crc8
  import telem_link_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (enable) begin
      crc <= crc8_update(crc, data, POLY);
    end
  end

endmodule

// File: rtl/telem_rx_deframer.sv
// Receive deframer: hunts for SOF, assembles PKT_BYTES payload bytes, checks
// the trailing CRC-8 and publishes good packets with statistics counters.
module telem_rx_deframer
  import telem_link_pkg::*;
#(
  parameter int         PKT_BYTES = PKT_BYTES_DEFAULT,
  parameter logic [7:0] SOF_CHAR  = K_SOF,
  parameter logic [7:0] IDLE_CHAR = K_IDLE,
  parameter logic [7:0] CRC_POLY  = CRC8_POLY,
  parameter int         CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_isk,
  input  logic                   rx_valid,
  input  logic                   rx_aligned,
  output logic [8*PKT_BYTES-1:0] packet,
  output logic                   packet_valid,
  output logic                   crc_err,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       err_count
);

  localparam int PW    = 8 * PKT_BYTES;
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  if (SOF_CHAR == IDLE_CHAR) begin : g_char_check
    $error("SOF_CHAR and IDLE_CHAR must be distinct K characters");
  end

  deframer_state_t  state, state_n;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    asm_q;
  logic [7:0]       crc;
  logic             frame_ended;

  logic is_sof;
  logic idx_clr, idx_inc, shift_en, crc_clr, crc_en;
  logic pkt_load, crc_bad, frm_bad, ended_set, ended_clr;

  assign is_sof = rx_isk && (rx_data == SOF_CHAR);

  telem_crc8 #(.POLY(CRC_POLY)) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (crc_clr),
    .enable (crc_en),
    .data   (rx_data),
    .crc    (crc)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    pkt_load  = 1'b0;
    crc_bad   = 1'b0;
    frm_bad   = 1'b0;
    ended_set = 1'b0;
    ended_clr = 1'b0;

    if (!rx_aligned) begin
      // Lost lock: drop any partial frame without blaming the link for stray bytes.
      state_n   = HUNT;
      ended_clr = 1'b1;
    end else if (rx_valid) begin
      unique case (state)
        HUNT: begin
          if (is_sof) begin
            state_n   = PAYLOAD;
            idx_clr   = 1'b1;
            crc_clr   = 1'b1;
            ended_clr = 1'b1;
          end else if (!rx_isk && frame_ended) begin
            frm_bad = 1'b1;
          end
        end
        PAYLOAD, CHECK: begin
          if (rx_isk) begin
            frm_bad = 1'b1;
            if (is_sof) begin
              state_n   = PAYLOAD;
              idx_clr   = 1'b1;
              crc_clr   = 1'b1;
              ended_clr = 1'b1;
            end else begin
              state_n   = HUNT;
              ended_set = 1'b1;
            end
          end else if (state == PAYLOAD) begin
            shift_en = 1'b1;
            crc_en   = 1'b1;
            if (idx == LAST_IDX) state_n = CHECK;
            else                 idx_inc = 1'b1;
          end else begin
            pkt_load  = (rx_data == crc);
            crc_bad   = (rx_data != crc);
            state_n   = HUNT;
            ended_set = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      idx          <= '0;
      asm_q        <= '0;
      frame_ended  <= 1'b0;
      packet       <= '0;
      packet_valid <= 1'b0;
      crc_err      <= 1'b0;
      frame_err    <= 1'b0;
      pkt_count    <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_n;
      packet_valid <= pkt_load;
      crc_err      <= crc_bad;
      frame_err    <= frm_bad;

      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;

      // First byte received ends up in the MSBs after PKT_BYTES shifts.
      if (shift_en) asm_q <= {asm_q[PW-9:0], rx_data};

      if (ended_clr)      frame_ended <= 1'b0;
      else if (ended_set) frame_ended <= 1'b1;

      if (pkt_load) packet <= asm_q;

      if (pkt_load && pkt_count != '1)              pkt_count <= pkt_count + 1'b1;
      if ((crc_bad || frm_bad) && err_count != '1)  err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_telem_rx_deframer.sv
// Directed bench for telem_rx_deframer: stimulus pushes expected pulses into a
// scoreboard queue, and a negedge monitor pops and compares each output pulse.
module tb_telem_rx_deframer;
  import telem_link_pkg::*;

  localparam int NB = 11;
  localparam int PW = 8 * NB;
  localparam logic [1:0] EV_NONE = 2'd0, EV_PKT = 2'd1, EV_CRC = 2'd2, EV_FRM = 2'd3;

  typedef struct {
    logic [1:0]    kind;
    logic [PW-1:0] pkt;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = K_IDLE;
  logic          rx_isk = 1'b1;
  logic          rx_valid = 1'b0;
  logic          rx_aligned = 1'b1;
  logic [PW-1:0] packet;
  logic          packet_valid, crc_err, frame_err;
  logic [15:0]   pkt_count, err_count;

  logic [PW-1:0] s_packet;
  logic          s_packet_valid, s_crc_err, s_frame_err;
  logic [3:0]    s_pkt_count, s_err_count;

  exp_t          q[$];
  exp_t          e;
  logic [1:0]    got;
  logic [PW-1:0] last_good = '0;
  int            cyc = 0;
  int            smp_cyc;
  int            n_checks = 0;
  int            n_errors = 0;

  telem_rx_deframer dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_isk(rx_isk),
    .rx_valid(rx_valid), .rx_aligned(rx_aligned), .packet(packet),
    .packet_valid(packet_valid), .crc_err(crc_err), .frame_err(frame_err),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  // Narrow-counter copy on the same stream to reach saturation quickly.
  telem_rx_deframer #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_isk(rx_isk),
    .rx_valid(rx_valid), .rx_aligned(rx_aligned), .packet(s_packet),
    .packet_valid(s_packet_valid), .crc_err(s_crc_err), .frame_err(s_frame_err),
    .pkt_count(s_pkt_count), .err_count(s_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC over the whole payload, MSB first.
  function automatic logic [7:0] ref_crc(input logic [PW-1:0] p);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = PW - 1; i >= 0; i--) begin
      fb = c[7] ^ p[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic k);
    @(negedge clk);
    rx_data    = d;
    rx_isk     = k;
    rx_valid   = 1'b1;
    rx_aligned = 1'b1;
    smp_cyc    = cyc + 1;
  endtask

  task automatic gap();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    rx_isk   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_byte(K_IDLE, 1'b1);
  endtask

  task automatic push(input logic [1:0] kind, input logic [PW-1:0] pkt);
    exp_t x;
    x.kind = kind;
    x.pkt  = pkt;
    x.cyc  = smp_cyc;
    q.push_back(x);
  endtask

  // Payload bytes plus CRC (XORed with crc_xor); optional random rx_valid gaps.
  task automatic send_body(input logic [PW-1:0] p, input logic [7:0] crc_xor, input bit gaps);
    for (int j = NB - 1; j >= 0; j--) begin
      if (gaps) repeat ($urandom_range(0, 2)) gap();
      send_byte(p[8*j +: 8], 1'b0);
    end
    if (gaps) repeat ($urandom_range(1, 2)) gap();
    send_byte(ref_crc(p) ^ crc_xor, 1'b0);
    if (crc_xor == 8'h00) begin
      last_good = p;
      push(EV_PKT, p);
    end else begin
      push(EV_CRC, last_good);
    end
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic [7:0] crc_xor, input bit gaps);
    send_byte(K_SOF, 1'b1);
    send_body(p, crc_xor, gaps);
  endtask

  task automatic drain();
    int n;
    idle(3);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (packet_valid || crc_err || frame_err)) begin
      got = packet_valid ? EV_PKT : (crc_err ? EV_CRC : EV_FRM);
      check("single pulse", packet_valid + crc_err + frame_err, 1);
      if (q.size() == 0) begin
        check("unexpected pulse", got, EV_NONE);
      end else begin
        e = q.pop_front();
        check("pulse kind", got, e.kind);
        check("pulse cycle", cyc, e.cyc);
        check("packet", packet, e.pkt);
      end
    end
  end

  logic [PW-1:0] p1 = 88'h0102030405060708090A0B;
  logic [PW-1:0] p3 = 88'h1112131415161718191A1B;
  logic [PW-1:0] p4 = 88'h112233445566778899AABB;
  logic [PW-1:0] pc;

  initial begin
    repeat (3) @(negedge clk);
    check("reset packet", packet, 0);
    check("reset pulses", {packet_valid, crc_err, frame_err}, 0);
    check("reset pkt_count", pkt_count, 0);
    check("reset err_count", err_count, 0);
    rst_n = 1'b1;

    // 1: idle then one good frame
    idle(5);
    send_frame(p1, 8'h00, 1'b0);
    drain();
    check("t1 pkt_count", pkt_count, 1);
    check("t1 err_count", err_count, 0);

    // 2: corrupted CRC
    send_frame(p1, 8'h01, 1'b0);
    drain();
    check("t2 packet kept", packet, p1);
    check("t2 pkt_count", pkt_count, 1);
    check("t2 err_count", err_count, 1);

    // 3: SOF interrupts a partial frame, second frame completes
    send_byte(K_SOF, 1'b1);
    for (int j = 0; j < 5; j++) send_byte(8'hE0 + 8'(j), 1'b0);
    send_byte(K_SOF, 1'b1);
    push(EV_FRM, last_good);
    send_body(p3, 8'h00, 1'b0);
    drain();
    check("t3 pkt_count", pkt_count, 2);
    check("t3 err_count", err_count, 2);

    // 4: alignment lost mid-payload, remainder is silently discarded
    send_byte(K_SOF, 1'b1);
    for (int j = 1; j <= 5; j++) send_byte(8'(j), 1'b0);
    @(negedge clk);
    rx_aligned = 1'b0;
    rx_valid   = 1'b1;
    rx_isk     = 1'b0;
    rx_data    = 8'h06;
    for (int j = 7; j <= 11; j++) send_byte(8'(j), 1'b0);
    send_byte(ref_crc(p1), 1'b0);
    idle(2);
    send_frame(p4, 8'h00, 1'b0);
    drain();
    check("t4 pkt_count", pkt_count, 3);
    check("t4 err_count", err_count, 2);

    // 5: rx_valid gaps inside a good frame
    send_frame(p1, 8'h00, 1'b1);
    drain();
    check("t5 pkt_count", pkt_count, 4);
    check("t5 err_count", err_count, 2);

    // 6: 1000 back-to-back counter frames from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    last_good = '0;
    @(negedge clk);
    check("rst2 pkt_count", pkt_count, 0);
    check("rst2 packet", packet, 0);
    rst_n = 1'b1;
    idle(2);
    for (int f = 0; f < 1000; f++) begin
      for (int j = 0; j < NB; j++) pc = {pc[PW-9:0], 8'(f * NB + j)};
      send_frame(pc, 8'h00, 1'b0);
    end
    drain();
    check("t6 pkt_count", pkt_count, 1000);
    check("t6 err_count", err_count, 0);
    check("t6 sat pkt_count", s_pkt_count, 4'hF);
    check("t6 sat err_count", s_err_count, 0);

    // error counter saturation on the narrow instance
    for (int f = 0; f < 20; f++) send_frame(p4, 8'h80, 1'b0);
    drain();
    check("sat err_count wide", err_count, 20);
    check("sat err_count narrow", s_err_count, 4'hF);
    check("sat pkt_count narrow", s_pkt_count, 4'hF);
    check("sat packet kept", packet, pc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
